// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int SERIAL_ADD_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/adder.sv
// 1-bit full adder shared by the serial datapath.
module adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one bit per clock through a 1-bit full adder.
// Optional SERIAL_ADD_ACC_EN adds an acc input that loads A from the last sum.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_ACC_EN
    input  logic             acc,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-2:0] r_sum_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [IW-1:0]    r_bit_idx;
    logic             w_s;
    logic             w_fa_cout;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_a_load;
    logic [WIDTH-1:0] w_sum_next;

    adder u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_fa_cout)
    );

`ifdef SERIAL_ADD_ACC_EN
    assign w_a_load = acc ? r_sum : op_a;
`else
    assign w_a_load = op_a;
`endif

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last     = (r_state == S_RUN) && (r_bit_idx == LAST_IDX);
    // New sum bit enters at the MSB; the oldest collected bit ends up at bit 0.
    assign w_sum_next = {w_s, r_sum_sr};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (r_bit_idx == LAST_IDX) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_sum_sr  <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_carry   <= 1'b0;
            r_bit_idx <= '0;
        end else if (w_accept) begin
            r_a_sr    <= w_a_load;
            r_b_sr    <= op_b;
            r_carry   <= cin;
            r_bit_idx <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_carry  <= w_fa_cout;
            r_sum_sr <= w_sum_next[WIDTH-1:1];
            // Index holds on the last bit so it never wraps within an operation.
            if (w_last) begin
                r_sum  <= w_sum_next;
                r_cout <= w_fa_cout;
            end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef SERIAL_ADD_ACC_EN
  logic         acc_in;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
`ifdef SERIAL_ADD_ACC_EN
    .acc   (acc_in),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operation, then wait (bounded) for done and check result/timing.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] exp_sum, input logic exp_cout);
    int cycles;
    int busy_cnt;
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    tick;
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    cin   = ~c;
    cycles   = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_cnt++;
      tick;
      cycles++;
    end
    check({tag, "_latency"}, cycles, 8);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
    tick;
    check({tag, "_done_pulse"}, {31'd0, done}, 0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    int done_c;
    int n_acc;
    int n_done;
    int dbl;
    int bad;
    int k;
    int acc_edge[8];
    logic prev_busy;
    logic prev_done;
    logic [W-1:0] sum_seen;

    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
`ifdef SERIAL_ADD_ACC_EN
    acc_in = 1'b0;
`endif
    tick;
    tick;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    rst = 1'b0;
    tick;

    run_op("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("add_a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // start pulses during RUN and DONE must be ignored
    op_a  = 8'h11;
    op_b  = 8'h22;
    cin   = 1'b0;
    start = 1'b1;
    tick;
    start    = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    done_c   = -1;
    sum_seen = '0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 3 || c == 8) begin
        start = 1'b1;
        op_a  = 8'hAA + 8'(c);
        op_b  = 8'h77;
      end else begin
        start = 1'b0;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_c   = c;
        sum_seen = sum;
      end
      tick;
    end
    start = 1'b0;
    check("ign_done_count", done_cnt, 1);
    check("ign_done_cycle", done_c, 8);
    check("ign_busy_cycles", busy_cnt, 8);
    check("ign_sum", {24'd0, sum_seen}, 32'h33);
    check("ign_cout", {31'd0, cout}, 0);

    // start held high: back-to-back accepts every WIDTH+2 cycles
    op_a      = 8'h01;
    op_b      = 8'h02;
    cin       = 1'b0;
    start     = 1'b1;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    n_acc     = 0;
    n_done    = 0;
    dbl       = 0;
    bad       = 0;
    for (int c = 1; c <= 35; c++) begin
      tick;
      if (busy === 1'b1 && prev_busy !== 1'b1) begin
        if (n_acc < 8) acc_edge[n_acc] = c;
        n_acc++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (prev_done === 1'b1) dbl++;
        if (sum !== 8'h03) bad++;
        if (busy === 1'b1) bad++;
      end
      prev_busy = busy;
      prev_done = done;
    end
    start = 1'b0;
    check("hold_accepts", n_acc, 4);
    check("hold_first_accept", acc_edge[0], 1);
    check("hold_gap1", acc_edge[1] - acc_edge[0], 10);
    check("hold_gap2", acc_edge[2] - acc_edge[1], 10);
    check("hold_gap3", acc_edge[3] - acc_edge[2], 10);
    check("hold_dones", n_done, 3);
    check("hold_double_done", dbl, 0);
    check("hold_bad_result", bad, 0);
    k = 0;
    while ((busy === 1'b1 || done === 1'b1) && k < 20) begin
      tick;
      k++;
    end
    check("hold_drain", {31'd0, busy | done}, 0);

    // reset in the middle of an operation
    op_a  = 8'h12;
    op_b  = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick;
    check("abort_busy_before", {31'd0, busy}, 1);
    rst = 1'b1;
    tick;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_sum", {24'd0, sum}, 0);
    check("abort_cout", {31'd0, cout}, 0);
    rst      = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_stays_idle", busy_cnt, 0);
    run_op("add_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

`ifdef SERIAL_ADD_ACC_EN
    acc_in = 1'b0;
    run_op("acc_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    acc_in = 1'b1;
    run_op("acc_plus_05", 8'hEE, 8'h05, 1'b0, 8'h35, 1'b0);
    acc_in = 1'b1;
    run_op("acc_plus_cb", 8'h77, 8'hCB, 1'b0, 8'h00, 1'b1);
    acc_in = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
